// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
// Used by instr_fetch_ctrl (FETCH_TIMEOUT_EN selects the response watchdog).
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } fetch_state_e;

  localparam logic [31:0] PC_STEP = 32'd4;

endpackage

// File: rtl/instr_fetch_ctrl.sv
// Single-outstanding instruction fetch FSM with redirect and hold handshake.
// Define FETCH_TIMEOUT_EN to add the WAIT watchdog that raises fetch_err.
module instr_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int          DataWidth = 32,
  parameter int          Address   = 8,
  parameter logic [31:0] RESET_PC  = 32'h0,
  parameter int          TIMEOUT   = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 mem_request,
  output logic                 mem_we_re,
  output logic [3:0]           mem_mask,
  output logic [Address-1:0]   mem_address,
  output logic [DataWidth-1:0] mem_data_in,
  input  logic                 mem_valid,
  input  logic [DataWidth-1:0] mem_data_out,
  input  logic                 redirect_valid,
  input  logic [31:0]          redirect_pc,
  output logic                 inst_valid,
  input  logic                 inst_ready,
  output logic [DataWidth-1:0] inst_data,
  output logic [31:0]          inst_pc,
  output logic                 fetch_err
);

  fetch_state_e         r_state;
  fetch_state_e         w_state;
  logic [31:0]          r_pc;
  logic [31:0]          w_pc;
  logic                 r_drop;
  logic                 w_drop;
  logic                 r_inst_valid;
  logic                 w_inst_valid;
  logic [DataWidth-1:0] r_inst_data;
  logic [DataWidth-1:0] w_inst_data;
  logic [31:0]          r_inst_pc;
  logic [31:0]          w_inst_pc;
  logic [31:0]          w_redir_pc;

`ifdef FETCH_TIMEOUT_EN
  localparam int CntW = $clog2(TIMEOUT + 1);

  logic [CntW-1:0] r_cnt;
  logic [CntW-1:0] w_cnt;
  logic            r_err;
  logic            w_err;
  logic            w_expired;

  assign w_expired = (r_cnt >= CntW'(TIMEOUT - 1));
`endif

  assign w_redir_pc  = redirect_pc & ~32'h3;

  assign mem_request = (r_state == REQ);
  assign mem_we_re   = 1'b0;
  assign mem_mask    = 4'hF;
  assign mem_address = r_pc[Address+1:2];
  assign mem_data_in = '0;
  assign inst_valid  = r_inst_valid;
  assign inst_data   = r_inst_data;
  assign inst_pc     = r_inst_pc;

  always_comb begin
    w_state      = r_state;
    w_pc         = r_pc;
    w_drop       = r_drop;
    w_inst_valid = r_inst_valid;
    w_inst_data  = r_inst_data;
    w_inst_pc    = r_inst_pc;
`ifdef FETCH_TIMEOUT_EN
    w_err        = 1'b0;
`endif
    unique case (r_state)
      IDLE: begin
        w_state = REQ;
        if (redirect_valid) w_pc = w_redir_pc;
      end
      REQ: begin
        w_state = WAIT;
        if (redirect_valid) begin
          w_pc   = w_redir_pc;
          w_drop = 1'b1;
        end
      end
      WAIT: begin
        if (redirect_valid) begin
          w_pc = w_redir_pc;
          if (mem_valid) begin
            w_state = REQ;
            w_drop  = 1'b0;
          end else begin
            w_drop  = 1'b1;
          end
        end else if (mem_valid) begin
          w_state = REQ;
          w_drop  = 1'b0;
          if (!r_drop) begin
            w_state      = HOLD;
            w_inst_valid = 1'b1;
            w_inst_data  = mem_data_out;
            w_inst_pc    = r_pc;
          end
`ifdef FETCH_TIMEOUT_EN
        end else if (w_expired) begin
          // Abandon the lost response and retry the same pc.
          w_state = REQ;
          w_drop  = 1'b0;
          w_err   = 1'b1;
`endif
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          w_state      = REQ;
          w_pc         = w_redir_pc;
          w_inst_valid = 1'b0;
        end else if (inst_ready) begin
          w_state      = REQ;
          w_pc         = r_pc + PC_STEP;
          w_inst_valid = 1'b0;
        end
      end
      default: w_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_pc         <= RESET_PC;
      r_drop       <= 1'b0;
      r_inst_valid <= 1'b0;
      r_inst_data  <= '0;
      r_inst_pc    <= '0;
    end else begin
      r_state      <= w_state;
      r_pc         <= w_pc;
      r_drop       <= w_drop;
      r_inst_valid <= w_inst_valid;
      r_inst_data  <= w_inst_data;
      r_inst_pc    <= w_inst_pc;
    end
  end

`ifdef FETCH_TIMEOUT_EN
  // Saturate so a held redirect cannot wrap the count.
  always_comb begin
    w_cnt = '0;
    if (r_state == WAIT && w_state == WAIT) begin
      w_cnt = (r_cnt == CntW'(TIMEOUT)) ? r_cnt : r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      r_cnt <= w_cnt;
      r_err <= w_err;
    end
  end

  assign fetch_err = r_err;
`else
  assign fetch_err = 1'b0;
`endif

endmodule

// File: doc/instr_fetch_ctrl.md
INSTR_FETCH_CTRL -- requirements
Module: instr_fetch_ctrl

Interface
REQ-001 Parameter DataWidth, default 32, SHALL set the instruction/data width.
REQ-002 Parameter Address, default 8, SHALL set the memory word-address width.
REQ-003 Parameter RESET_PC, default 32'h0, SHALL set the byte PC loaded at reset.
REQ-004 Parameter TIMEOUT, default 15, SHALL set the response-wait limit in cycles (used only under FETCH_TIMEOUT_EN).
REQ-005 Port clk, input, 1 bit, SHALL be the single clock; all state changes on its rising edge.
REQ-006 Port rst, input, 1 bit, SHALL be the synchronous, active-high reset.
REQ-007 Port mem_request, output, 1 bit, SHALL be the read request to the instruction memory.
REQ-008 Port mem_we_re, output, 1 bit, SHALL be constant 0 (read only).
REQ-009 Port mem_mask, output, 4 bits, SHALL be constant 4'hF.
REQ-010 Port mem_address, output, Address bits, SHALL equal pc[Address+1:2].
REQ-011 Port mem_data_in, output, DataWidth bits, SHALL be constant 0.
REQ-012 Port mem_valid, input, 1 bit, SHALL be the memory response-valid strobe.
REQ-013 Port mem_data_out, input, DataWidth bits, SHALL be the memory read data, sampled only when mem_valid=1.
REQ-014 Port redirect_valid, input, 1 bit, SHALL request a PC change (branch/jump).
REQ-015 Port redirect_pc, input, 32 bits, SHALL be the target byte PC; bits [1:0] are ignored.
REQ-016 Port inst_valid, output, 1 bit, SHALL flag a valid instruction to the core.
REQ-017 Port inst_ready, input, 1 bit, SHALL be core acceptance; a transfer occurs when inst_valid and inst_ready are both 1.
REQ-018 Port inst_data, output, DataWidth bits, SHALL be the fetched instruction.
REQ-019 Port inst_pc, output, 32 bits, SHALL be the byte PC of inst_data.
REQ-020 Port fetch_err, output, 1 bit, SHALL pulse for one cycle on a response timeout.

Function
REQ-021 The FSM SHALL have states IDLE, REQ, WAIT and HOLD.
REQ-022 IDLE SHALL advance to REQ unconditionally on the next cycle.
REQ-023 In REQ the block SHALL drive mem_request=1 for exactly one cycle, then enter WAIT.
REQ-024 mem_request SHALL be 0 in all states other than REQ.
REQ-025 In WAIT, when mem_valid=1 and drop=0, the block SHALL register inst_data<=mem_data_out, inst_pc<=pc and inst_valid<=1, then enter HOLD.
REQ-026 In HOLD, inst_valid, inst_data and inst_pc SHALL stay stable until inst_ready=1; on that transfer pc SHALL become pc+4 (mod 2^32), inst_valid SHALL go to 0, and the FSM SHALL enter REQ.
REQ-027 A fetch SHALL take at least 3 cycles (REQ, WAIT, HOLD); there SHALL be at most one outstanding memory request.
REQ-028 Redirect priority: redirect_valid=1 SHALL override all other transitions and load pc<={redirect_pc[31:2],2'b00}.
  - Redirect in IDLE or HOLD: the FSM SHALL enter REQ and inst_valid SHALL be 0 on the next cycle; a simultaneous inst_ready transfer SHALL still count as consumed.
  - Redirect in REQ: the request SHALL still issue, the FSM SHALL enter WAIT, and drop SHALL be set to 1.
  - Redirect in WAIT without mem_valid: the FSM SHALL stay in WAIT and set drop=1.
  - Redirect in WAIT with mem_valid: the response SHALL be discarded and the FSM SHALL enter REQ.
REQ-029 In WAIT, mem_valid with drop=1 SHALL discard the response, clear drop, and enter REQ.
REQ-030 mem_valid received outside WAIT SHALL be ignored.

Reset
REQ-031 While rst=1 at a clock edge, the block SHALL set state=IDLE, pc=RESET_PC, drop=0, timeout counter=0, mem_request=0, inst_valid=0, inst_data=0, inst_pc=0 and fetch_err=0.
REQ-032 A reset mid-transaction SHALL abandon the transaction, and a later mem_valid SHALL be ignored per REQ-030.

Configuration
REQ-033 With macro FETCH_TIMEOUT_EN defined, a counter SHALL count cycles spent in WAIT without mem_valid.
  - On reaching TIMEOUT, fetch_err SHALL pulse for one cycle, drop SHALL clear, and the FSM SHALL re-enter REQ at the same pc.
  - The counter SHALL clear on leaving WAIT.
REQ-034 With FETCH_TIMEOUT_EN undefined, fetch_err SHALL be tied to 0, no counter SHALL exist, and WAIT SHALL persist until mem_valid.

Structure
REQ-035 Package fetch_pkg SHALL hold the fetch_state_e typedef (IDLE/REQ/WAIT/HOLD) and the PC_STEP=4 constant.
REQ-036 The block SHALL be a single module with no sub-modules; the timeout counter SHALL be inline under the macro.

Verification
REQ-037 Reset release with RESET_PC=0 and a 1-cycle-latency memory SHALL produce mem_request at mem_address 0 on cycle 2, and inst_valid with inst_pc=0 on cycle 4.
REQ-038 With inst_ready held at 1 and memory words k*0x11, the bench SHALL see inst_pc 0,4,8,12 with inst_data 0x00,0x11,0x22,0x33, one every 3 cycles.
REQ-039 With inst_ready=0 for 5 cycles in HOLD, inst_data and inst_pc SHALL stay stable, and no mem_request SHALL issue.
REQ-040 redirect_valid=1 with redirect_pc=0x43 in the REQ cycle SHALL cause the pending response to be dropped, the next request to use mem_address 0x10, and the next inst_pc to be 0x40.
REQ-041 Under FETCH_TIMEOUT_EN, a memory that never asserts mem_valid SHALL cause fetch_err to pulse after 15 WAIT cycles and mem_request to re-issue at the same address.
REQ-042 rst=1 asserted in WAIT followed by a late mem_valid SHALL leave inst_valid at 0, with the first post-reset request at RESET_PC.
